fetch_stage: RTL and testbench

// - Instruction-fetch stage of the 3-stage RV32I pipeline. Directly upstream of decode and the immediate

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/fetch_hold_reg.sv | 35 +++
 rtl/fetch_stage.sv | 170 +++++++++++++++++
 tb/tb_fetch_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the front end.
// Holds the base opcode constants that downstream decode and the immediate
// sign-extender key on, the canonical NOP word, and the fetch FSM state type.
package riscv_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_reg.sv
// One-entry skid buffer for a fetched {instr, pc} pair. It catches a memory
// response that arrives while decode is stalled with the output already full.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   load              capture instr_in/pc_in and mark the entry valid
//   clear             empty the entry (wins over load)
//   instr_in, pc_in   data to capture
//   valid, instr, pc  current entry contents
module fetch_hold_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 3-stage RV32I pipeline.
// Owns the PC, keeps at most one instruction-memory request outstanding,
// buffers one instruction against decode stalls, and flushes on redirects.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   imem_req_valid/ready, imem_addr   fetch request handshake (word aligned)
//   imem_rsp_valid, imem_rsp_data     in-order response, one per request
//   de_stall                          decode cannot accept; if_* held
//   redirect_valid, redirect_pc       execute-stage redirect, flushes stage
//   if_valid, if_instr, if_pc,
//   if_pc_plus4, if_opcode,
//   if_imm12, if_imm20                registered instruction to decode
//
// state | meaning
// FETCH | request for pc is offered to memory
// WAIT  | one request outstanding; drop_q marks its response as stale
// HOLD  | response parked in the hold reg until decode frees the output
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        de_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [6:0]  if_opcode,
    output logic [11:0] if_imm12,
    output logic [19:0] if_imm20
);

    import riscv_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;

    logic         out_valid_q;
    logic [31:0]  out_instr_q;
    logic [31:0]  out_pc_q;

    logic         out_free;
    logic         out_load;
    logic [31:0]  load_instr;
    logic [31:0]  load_pc;

    logic         hold_load;
    logic         hold_clear;
    logic         hold_valid;
    logic [31:0]  hold_instr;
    logic [31:0]  hold_pc;

    fetch_hold_reg u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_load),
        .clear    (hold_clear),
        .instr_in (imem_rsp_data),
        .pc_in    (pc_q),
        .valid    (hold_valid),
        .instr    (hold_instr),
        .pc       (hold_pc)
    );

    // A bubble on the output may be overwritten even while decode stalls.
    assign out_free = !out_valid_q || !de_stall;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        out_load   = 1'b0;
        load_instr = imem_rsp_data;
        load_pc    = pc_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;

        case (state_q)
            FETCH: begin
                // A redirect coinciding with acceptance makes the in-flight
                // request stale; its response must be swallowed in WAIT.
                if (imem_req_ready) begin
                    state_d = WAIT;
                    drop_d  = redirect_valid;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = FETCH;
                    drop_d  = 1'b0;
                    if (!redirect_valid && !drop_q) begin
                        pc_d = pc_q + 32'd4;
                        if (out_free) begin
                            out_load = 1'b1;
                        end else begin
                            hold_load = 1'b1;
                            state_d   = HOLD;
                        end
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_d = FETCH;
                end else if (hold_valid && !de_stall) begin
                    out_load   = 1'b1;
                    load_instr = hold_instr;
                    load_pc    = hold_pc;
                    hold_clear = 1'b1;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (redirect_valid) begin
            pc_d       = redirect_pc & ~32'd3;
            hold_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC & ~32'd3;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= NOP_INSTR;
            out_pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            if (redirect_valid) begin
                out_valid_q <= 1'b0;
                out_instr_q <= NOP_INSTR;
            end else if (out_load) begin
                out_valid_q <= 1'b1;
                out_instr_q <= load_instr;
                out_pc_q    <= load_pc;
            end else if (!de_stall) begin
                out_valid_q <= 1'b0;
                out_instr_q <= NOP_INSTR;
            end
        end
    end

    assign imem_req_valid = rst_n && (state_q == FETCH);
    assign imem_addr      = pc_q;

    assign if_valid    = out_valid_q;
    assign if_instr    = out_instr_q;
    assign if_pc       = out_pc_q;
    assign if_pc_plus4 = out_pc_q + 32'd4;
    assign if_opcode   = out_instr_q[6:0];
    assign if_imm12    = out_instr_q[31:20];
    assign if_imm20    = out_instr_q[31:12];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        de_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // index 0: RESET_PC = 0, index 1: RESET_PC = FFFF_FFFC (same stimulus)
    logic        rv   [2];
    logic [31:0] ad   [2];
    logic        iv   [2];
    logic [31:0] ii   [2];
    logic [31:0] ipc  [2];
    logic [31:0] ip4  [2];
    logic [6:0]  iop  [2];
    logic [11:0] i12  [2];
    logic [19:0] i20  [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(rv[0]), .imem_req_ready(imem_req_ready), .imem_addr(ad[0]),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .de_stall(de_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(iv[0]), .if_instr(ii[0]), .if_pc(ipc[0]), .if_pc_plus4(ip4[0]),
        .if_opcode(iop[0]), .if_imm12(i12[0]), .if_imm20(i20[0])
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(rv[1]), .imem_req_ready(imem_req_ready), .imem_addr(ad[1]),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .de_stall(de_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(iv[1]), .if_instr(ii[1]), .if_pc(ipc[1]), .if_pc_plus4(ip4[1]),
        .if_opcode(iop[1]), .if_imm12(i12[1]), .if_imm20(i20[1])
    );

    // Reference model: request bookkeeping as flags, a one-slot parking area,
    // and the visible output word. PC-related values kept per instance.
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        m_busy;      // a request has been accepted and not answered
    logic        m_disc;      // the outstanding answer belongs to a flushed path
    logic        m_park;      // an answer is parked awaiting decode
    logic [31:0] m_park_instr;
    logic [31:0] m_park_pc [2];
    logic        m_ov;
    logic [31:0] m_oi;
    logic [31:0] m_opc [2];
    logic [31:0] m_pc  [2];
    logic        m_acc;
    logic        mem_pending = 1'b0;

    function automatic logic [31:0] rst_pc(int k);
        return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
    endfunction

    task automatic model_edge();
        logic acc, got, load;
        logic [31:0] li;
        logic [31:0] lp [2];
        if (!rst_n) begin
            m_busy = 1'b0; m_disc = 1'b0; m_park = 1'b0;
            m_ov = 1'b0; m_oi = NOP; m_acc = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_pc[k] = rst_pc(k);
                m_opc[k] = 32'h0;
            end
            return;
        end
        acc  = !m_busy && !m_park && imem_req_ready;
        got  = m_busy && imem_rsp_valid;
        load = 1'b0;
        li   = NOP;
        lp[0] = 32'h0; lp[1] = 32'h0;
        if (redirect_valid) begin
            for (int k = 0; k < 2; k++) m_pc[k] = {redirect_pc[31:2], 2'b00};
            m_park = 1'b0;
            if (m_busy) begin
                if (got) begin m_busy = 1'b0; m_disc = 1'b0; end
                else m_disc = 1'b1;
            end else if (acc) begin
                m_busy = 1'b1; m_disc = 1'b1;
            end
            m_ov = 1'b0; m_oi = NOP;
        end else begin
            if (m_park) begin
                if (!de_stall) begin
                    load = 1'b1; li = m_park_instr; lp = m_park_pc; m_park = 1'b0;
                end
            end else if (got) begin
                m_busy = 1'b0;
                if (m_disc) begin
                    m_disc = 1'b0;
                end else if (!m_ov || !de_stall) begin
                    load = 1'b1; li = imem_rsp_data;
                    for (int k = 0; k < 2; k++) begin lp[k] = m_pc[k]; m_pc[k] += 32'd4; end
                end else begin
                    m_park = 1'b1; m_park_instr = imem_rsp_data;
                    for (int k = 0; k < 2; k++) begin m_park_pc[k] = m_pc[k]; m_pc[k] += 32'd4; end
                end
            end else if (acc) begin
                m_busy = 1'b1;
            end
            if (load) begin
                m_ov = 1'b1; m_oi = li; m_opc = lp;
            end else if (!de_stall) begin
                m_ov = 1'b0; m_oi = NOP;
            end
        end
        m_acc = acc;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("m%0d.req_valid", k), {31'b0, rv[k]}, {31'b0, rst_n && !m_busy && !m_park});
            chk($sformatf("m%0d.addr", k), ad[k], m_pc[k]);
            chk($sformatf("m%0d.if_valid", k), {31'b0, iv[k]}, {31'b0, m_ov});
            chk($sformatf("m%0d.if_instr", k), ii[k], m_oi);
            chk($sformatf("m%0d.if_opcode", k), {25'b0, iop[k]}, {25'b0, m_oi[6:0]});
            chk($sformatf("m%0d.if_imm12", k), {20'b0, i12[k]}, {20'b0, m_oi[31:20]});
            chk($sformatf("m%0d.if_imm20", k), {12'b0, i20[k]}, {12'b0, m_oi[31:12]});
            if (m_ov) begin
                chk($sformatf("m%0d.if_pc", k), ipc[k], m_opc[k]);
                chk($sformatf("m%0d.if_pc_plus4", k), ip4[k], m_opc[k] + 32'd4);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        if (!rst_n) mem_pending = 1'b0;
        else begin
            if (imem_rsp_valid) mem_pending = 1'b0;
            if (m_acc) mem_pending = 1'b1;
        end
        #1;
        check_model();
    endtask

    task automatic drive(logic rdy, logic rsp, logic [31:0] dat, logic stl, logic rdr, logic [31:0] rpc);
        imem_req_ready = rdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = dat;
        de_stall       = stl;
        redirect_valid = rdr;
        redirect_pc    = rpc;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);

        // reset
        cyc(); cyc();
        chk("rst.req_valid", {31'b0, rv[0]}, 32'd0);
        chk("rst.if_valid", {31'b0, iv[0]}, 32'd0);
        chk("rst.if_instr", ii[0], 32'h13);
        chk("rst.if_pc", ipc[0], 32'h0);
        chk("rst.if_pc_plus4", ip4[0], 32'h4);
        rst_n = 1'b1;
        #1;
        chk("rel.req_valid", {31'b0, rv[0]}, 32'd1);
        chk("rel.addr", ad[0], 32'h0);

        // stream with a one-cycle memory
        drive(1, 0, 32'h0, 0, 0, 32'h0);                 cyc();
        chk("s0.req_valid", {31'b0, rv[0]}, 32'd0);
        drive(0, 1, 32'h0050_0093, 0, 0, 32'h0);         cyc();
        chk("s0.if_valid", {31'b0, iv[0]}, 32'd1);
        chk("s0.if_pc", ipc[0], 32'h0);
        chk("s0.if_opcode", {25'b0, iop[0]}, 32'h13);
        chk("s0.if_imm12", {20'b0, i12[0]}, 32'h005);
        chk("s0.addr", ad[0], 32'h4);
        drive(1, 0, 32'h0, 0, 0, 32'h0);                 cyc();
        drive(0, 1, 32'h00A0_0113, 0, 0, 32'h0);         cyc();
        chk("s1.if_pc", ipc[0], 32'h4);
        chk("s1.if_imm12", {20'b0, i12[0]}, 32'h00A);

        // stall with output full
        drive(1, 0, 32'h0, 1, 0, 32'h0);                 cyc();
        chk("st.held_instr", ii[0], 32'h00A0_0113);
        drive(0, 1, 32'h0FF0_0193, 1, 0, 32'h0);         cyc();
        chk("st.no_req", {31'b0, rv[0]}, 32'd0);
        chk("st.held_pc", ipc[0], 32'h4);
        drive(0, 0, 32'h0, 1, 0, 32'h0);                 cyc();
        chk("st.still_held", ii[0], 32'h00A0_0113);
        drive(0, 0, 32'h0, 0, 0, 32'h0);                 cyc();
        chk("st.release_instr", ii[0], 32'h0FF0_0193);
        chk("st.release_pc", ipc[0], 32'h8);
        chk("st.next_addr", ad[0], 32'hC);

        // redirect while waiting
        drive(1, 0, 32'h0, 0, 0, 32'h0);                 cyc();
        drive(0, 0, 32'h0, 0, 1, 32'h0000_0103);         cyc();
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);         cyc();
        chk("rw.if_valid", {31'b0, iv[0]}, 32'd0);
        chk("rw.addr", ad[0], 32'h100);
        drive(1, 0, 32'h0, 0, 0, 32'h0);                 cyc();
        drive(0, 1, 32'h0070_0213, 0, 0, 32'h0);         cyc();
        chk("rw.new_pc", ipc[0], 32'h100);

        // redirect together with response under stall
        drive(1, 0, 32'h0, 1, 0, 32'h0);                 cyc();
        drive(0, 1, 32'h1111_1113, 1, 1, 32'h0000_0200); cyc();
        chk("rr.if_valid", {31'b0, iv[0]}, 32'd0);
        chk("rr.addr", ad[0], 32'h200);
        chk("rr.req_valid", {31'b0, rv[0]}, 32'd1);

        // redirect in the cycle the request is accepted
        drive(1, 0, 32'h0, 0, 1, 32'h0000_0300);         cyc();
        drive(0, 1, 32'h2222_2213, 0, 0, 32'h0);         cyc();
        chk("ra.addr", ad[0], 32'h300);
        chk("ra.if_valid", {31'b0, iv[0]}, 32'd0);

        // wrap instance and reset during WAIT
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);                 cyc(); cyc();
        rst_n = 1'b1;
        drive(1, 0, 32'h0, 0, 0, 32'h0);                 cyc();
        drive(0, 1, 32'h0010_0093, 0, 0, 32'h0);         cyc();
        chk("wr.if_pc", ipc[1], 32'hFFFF_FFFC);
        chk("wr.if_pc_plus4", ip4[1], 32'h0);
        chk("wr.addr", ad[1], 32'h0);
        drive(1, 0, 32'h0, 0, 0, 32'h0);                 cyc();
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);                 cyc();
        rst_n = 1'b1;
        drive(0, 1, 32'hBAD0_0013, 0, 0, 32'h0);         cyc();
        chk("wr.stray_if_valid", {31'b0, iv[1]}, 32'd0);
        chk("wr.restart_addr", ad[1], 32'hFFFF_FFFC);
        chk("wr.restart_req", {31'b0, rv[1]}, 32'd1);
        drive(0, 0, 32'h0, 0, 0, 32'h0);                 cyc();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            imem_req_ready = 1'($urandom_range(0, 1));
            imem_rsp_valid = mem_pending && ($urandom_range(0, 2) != 0);
            imem_rsp_data  = $urandom;
            de_stall       = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
